// File: rtl/decode_bitstream.sv
// Bit-stream extractor for the LZS decoder. FIFO words are packed into a
// 2*IN_W left-justified buffer; the oldest MAX_W bits are peeked MSB-first,
// a controller-chosen number of bits is consumed per ack, and align_req
// drops bits up to the next byte boundary of the consumed stream.
module decode_bitstream #(
    parameter int IN_W  = 64,
    parameter int MAX_W = 13,
    parameter int WW    = 4,
    parameter int CW    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             fo_full,
    input  logic             src_empty,
    input  logic [IN_W-1:0]  fi,
    output logic             m_src_getn,
    input  logic [WW-1:0]    stream_width,
    input  logic             stream_ack,
    input  logic             align_req,
    output logic [MAX_W-1:0] stream_data,
    output logic             stream_valid,
    output logic [CW-1:0]    bit_cnt
);

    localparam int BW = 2 * IN_W;

    logic [BW-1:0] r_buf;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_pos;

    logic          w_room;
    logic          w_pop;
    logic [WW-1:0] w_n;
    logic [BW-1:0] w_buf1;
    logic [CW-1:0] w_cnt1;
    logic [2:0]    w_pos1;
    logic [2:0]    w_a;
    logic [BW-1:0] w_buf2;
    logic [CW-1:0] w_cnt2;
    logic [2:0]    w_pos2;
    logic [BW-1:0] w_fill;
    logic [BW-1:0] w_buf3;
    logic [CW-1:0] w_cnt3;

    // Pop eligibility looks at the pre-consume count so the pop strobe never
    // depends on stream_ack; with cnt <= IN_W a fresh word always fits.
    assign w_room       = (r_cnt <= CW'(IN_W));
    assign w_pop        = ce & ~fo_full & ~src_empty & w_room & ~rst;
    assign m_src_getn   = ~w_pop;

    // Zero fill on every shift keeps bits beyond bit_cnt at 0.
    assign stream_data  = r_buf[BW-1 -: MAX_W];
    assign stream_valid = (r_cnt >= CW'(stream_width));
    assign bit_cnt      = r_cnt;

    // Next-state: consume, then byte-align, then append the popped word.
    always_comb begin
        w_n    = (stream_ack & stream_valid) ? stream_width : '0;
        w_buf1 = r_buf << w_n;
        w_cnt1 = r_cnt - CW'(w_n);
        w_pos1 = r_pos + w_n[2:0];

        // (8 - pos) mod 8 falls out of 3-bit wraparound.
        w_a    = align_req ? (3'd0 - w_pos1) : 3'd0;
        w_buf2 = w_buf1 << w_a;
        w_cnt2 = w_cnt1 - CW'(w_a);
        w_pos2 = align_req ? 3'd0 : w_pos1;

        // New word lands directly after the last valid bit.
        w_fill = {fi, {IN_W{1'b0}}} >> w_cnt2;
        w_buf3 = w_pop ? (w_buf2 | w_fill) : w_buf2;
        w_cnt3 = w_pop ? (w_cnt2 + CW'(IN_W)) : w_cnt2;
    end

    // Buffer, count and byte phase registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf <= '0;
            r_cnt <= '0;
            r_pos <= '0;
        end else begin
            r_buf <= w_buf3;
            r_cnt <= w_cnt3;
            r_pos <= w_pos2;
        end
    end

    // Widths above MAX_W would consume bits the controller never saw.
    always_ff @(posedge clk) begin
        if (!rst && stream_ack) begin
            assert (stream_width <= WW'(MAX_W));
        end
    end

endmodule
